// File: rtl/uart_frame_tx_if.sv
// Payload write handshake between an upstream producer and uart_frame_tx.
interface uart_frame_tx_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_last;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, output wr_last, input wr_ready);
  modport slave  (input wr_data, input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/uart_frame_tx.sv
// Buffers one payload and sends it to uart_transceiver as HDR0 HDR1 LEN payload check.
// Define UART_FRAME_CRC16_EN for a CRC-16/CCITT-FALSE check (two bytes) instead of the 8-bit checksum.
module uart_frame_tx #(
  parameter int         MAX_LEN    = 64,
  parameter int         ADDR_W     = 6,
  parameter int         TX_TIMEOUT = 6000,
  parameter logic [7:0] HDR0       = 8'hEB,
  parameter logic [7:0] HDR1       = 8'h90
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_frame_tx_if.slave wr,
  output logic           frame_busy,
  output logic           frame_done,
  output logic           frame_err,
  output logic [7:0]     uart_tx_data,
  output logic           uart_tx_data_ready,
  input  logic           uart_tx_status,
  input  logic           uart_tx_over
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TX_TIMEOUT + 1);
`ifdef UART_FRAME_CRC16_EN
  localparam int              CHK_W    = 16;
  localparam logic [CHK_W-1:0] CHK_INIT = 16'hFFFF;
`else
  localparam int              CHK_W    = 8;
  localparam logic [CHK_W-1:0] CHK_INIT = 8'h00;
`endif

  typedef enum logic [2:0] {
    S_FILL = 3'd0, S_HDR0 = 3'd1, S_HDR1 = 3'd2, S_LEN = 3'd3,
    S_DATA = 3'd4, S_CHK0 = 3'd5, S_CHK1 = 3'd6
  } state_e;
  typedef enum logic {PH_ISSUE = 1'b0, PH_WAIT = 1'b1} phase_e;

  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] acc, input logic [7:0] b);
    logic [CHK_W-1:0] c;
`ifdef UART_FRAME_CRC16_EN
    c = acc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
`else
    c = acc + b;
`endif
    return c;
  endfunction

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       len_q, len_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CHK_W-1:0] chk_q, chk_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wr_ready_q, wr_ready_d;
  logic             mem_we_s;
  logic             finish_s;
  logic [7:0]       chk_first_s;
  logic [7:0]       pay_mem_q [2**ADDR_W];
  logic             status_unused_s;

  // Transceiver busy is informational only; pacing relies on uart_tx_over.
  assign status_unused_s = uart_tx_status;

`ifdef UART_FRAME_CRC16_EN
  assign chk_first_s = chk_q[15:8];
`else
  assign chk_first_s = ~chk_q;
`endif

  // Next-state, byte selection and payload/check bookkeeping.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    count_d    = count_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    timer_d    = timer_q;
    chk_d      = chk_q;
    tx_data_d  = tx_data_q;
    tx_ready_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_ready_d = wr_ready_q;
    mem_we_s   = 1'b0;
    finish_s   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (wr.wr_valid && wr_ready_q) begin
          mem_we_s = 1'b1;
          count_d  = count_q + CNT_W'(1);
          chk_d    = chk_update(chk_q, wr.wr_data);
          // The MAX_LEN-th byte commits the frame even without wr_last.
          if (wr.wr_last || (count_q == CNT_W'(MAX_LEN - 1))) begin
            len_d      = 8'(count_q) + 8'd1;
            state_d    = S_HDR0;
            phase_d    = PH_ISSUE;
            tx_data_d  = HDR0;
            tx_ready_d = 1'b1;
            busy_d     = 1'b1;
            wr_ready_d = 1'b0;
          end else begin
            wr_ready_d = 1'b1;
          end
        end else begin
          wr_ready_d = (count_q < CNT_W'(MAX_LEN));
        end
      end
      default: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
          timer_d = '0;
        end else if (uart_tx_over) begin
          phase_d    = PH_ISSUE;
          tx_ready_d = 1'b1;
          case (state_q)
            S_HDR0: begin state_d = S_HDR1; tx_data_d = HDR1; end
            S_HDR1: begin state_d = S_LEN;  tx_data_d = len_q; end
            S_LEN: begin
              state_d   = S_DATA;
              rd_ptr_d  = '0;
              tx_data_d = pay_mem_q[ADDR_W'(0)];
            end
            S_DATA: begin
              if (8'(rd_ptr_q) == (len_q - 8'd1)) begin
                state_d   = S_CHK0;
                tx_data_d = chk_first_s;
              end else begin
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                tx_data_d = pay_mem_q[rd_ptr_q + ADDR_W'(1)];
              end
            end
`ifdef UART_FRAME_CRC16_EN
            S_CHK0: begin state_d = S_CHK1; tx_data_d = chk_q[7:0]; end
`endif
            default: begin
              tx_ready_d = 1'b0;
              finish_s   = 1'b1;
            end
          endcase
        end else if (timer_q == TMR_W'(TX_TIMEOUT)) begin
          err_d    = 1'b1;
          finish_s = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
    endcase
    // Completion and timeout both drop the frame and reopen the buffer at address 0.
    if (finish_s) begin
      state_d    = S_FILL;
      phase_d    = PH_ISSUE;
      count_d    = '0;
      chk_d      = CHK_INIT;
      busy_d     = 1'b0;
      wr_ready_d = 1'b1;
      done_d     = ~err_d;
    end else begin
      done_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      phase_q    <= PH_ISSUE;
      count_q    <= '0;
      len_q      <= 8'd0;
      rd_ptr_q   <= '0;
      timer_q    <= '0;
      chk_q      <= CHK_INIT;
      tx_data_q  <= 8'd0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      timer_q    <= timer_d;
      chk_q      <= chk_d;
      tx_data_q  <= tx_data_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      pay_mem_q[count_q[ADDR_W-1:0]] <= wr.wr_data;
    end
  end

  assign wr.wr_ready         = wr_ready_q;
  assign frame_busy          = busy_q;
  assign frame_done          = done_q;
  assign frame_err           = err_q;
  assign uart_tx_data        = tx_data_q;
  assign uart_tx_data_ready  = tx_ready_q;

endmodule
